// File: rtl/xeng_corr_apply.sv
// Removes the offset-binary bias from X-engine accumulations, saturates to OUT_WIDTH
// and tracks the baseline index within each accumulation window. Fixed 3-cycle latency.
module xeng_corr_apply #(
    parameter int BITWIDTH   = 4,
    parameter int N_ANTS     = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int CORR_WIDTH = 16,
    parameter int OUT_WIDTH  = 24,
    parameter int RE_CONST   = 0,
    localparam int N_BLS     = N_ANTS * (N_ANTS + 1) / 2,
    localparam int IDX_W     = (N_BLS > 1) ? $clog2(N_BLS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync,
    input  logic                    din_vld,
    input  logic [8*ACC_WIDTH-1:0]  din,
    input  logic [8*CORR_WIDTH-1:0] corr,
    input  logic                    last_triangle_in,
    input  logic                    buf_sel_in,
    output logic [8*OUT_WIDTH-1:0]  dout,
    output logic                    dout_vld,
    output logic                    sync_out,
    output logic                    last_triangle_out,
    output logic                    buf_sel_out,
    output logic [IDX_W-1:0]        bl_idx,
    output logic                    window_done,
    output logic                    sat_flag
);

    localparam int SHIFT = BITWIDTH - 1;
    localparam int IW    = ((ACC_WIDTH > CORR_WIDTH + SHIFT) ? ACC_WIDTH : CORR_WIDTH + SHIFT) + 2;
    localparam logic signed [IW-1:0] RE_C    = IW'(RE_CONST);
    localparam logic signed [IW-1:0] ZERO    = '0;
    localparam logic signed [IW-1:0] OUT_MAX = {{(IW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IW-1:0] OUT_MIN = {{(IW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_BLS - 1);

    logic signed [IW-1:0]    raw_s1  [8];
    logic signed [IW-1:0]    corr_s1 [8];
    logic signed [IW-1:0]    sum_s2  [8];
    logic [OUT_WIDTH-1:0]    sat_val [8];
    logic [7:0]              clamp;

    logic s1_vld, s1_sync, s1_lt, s1_bs;
    logic s2_vld, s2_sync, s2_lt, s2_bs;

    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] idx_cur;
    logic             sat_any;

    // S1: capture raw products and the scaled, sign-extended corrections
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                raw_s1[i]  <= '0;
                corr_s1[i] <= '0;
            end
            {s1_vld, s1_sync, s1_lt, s1_bs} <= '0;
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                raw_s1[i]  <= IW'(signed'(din[(7-i)*ACC_WIDTH +: ACC_WIDTH]));
                corr_s1[i] <= IW'(signed'(corr[(7-i)*CORR_WIDTH +: CORR_WIDTH])) <<< SHIFT;
            end
            {s1_vld, s1_sync, s1_lt, s1_bs} <= {din_vld, sync, last_triangle_in, buf_sel_in};
        end
    end

    // S2: bias removal; the constant term applies to real lanes only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) sum_s2[i] <= '0;
            {s2_vld, s2_sync, s2_lt, s2_bs} <= '0;
        end else begin
            for (int unsigned i = 0; i < 8; i++)
                sum_s2[i] <= raw_s1[i] - corr_s1[i] + ((i < 4) ? RE_C : ZERO);
            {s2_vld, s2_sync, s2_lt, s2_bs} <= {s1_vld, s1_sync, s1_lt, s1_bs};
        end
    end

    always_comb begin
        clamp = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sat_val[i] = sum_s2[i][OUT_WIDTH-1:0];
            if (sum_s2[i] > OUT_MAX) begin
                sat_val[i] = OUT_MAX[OUT_WIDTH-1:0];
                clamp[i]   = 1'b1;
            end else if (sum_s2[i] < OUT_MIN) begin
                sat_val[i] = OUT_MIN[OUT_WIDTH-1:0];
                clamp[i]   = 1'b1;
            end
        end
        sat_any = s2_vld & (|clamp);
        idx_cur = s2_sync ? '0 : next_idx;
    end

    // S3: output register; next_idx holds the index the next valid beat will take,
    // so a sync without data still makes the following valid beat index 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout              <= '0;
            dout_vld          <= 1'b0;
            sync_out          <= 1'b0;
            last_triangle_out <= 1'b0;
            buf_sel_out       <= 1'b0;
            bl_idx            <= '0;
            next_idx          <= '0;
            sat_flag          <= 1'b0;
        end else begin
            if (s2_vld) begin
                for (int unsigned i = 0; i < 8; i++)
                    dout[(7-i)*OUT_WIDTH +: OUT_WIDTH] <= sat_val[i];
            end
            dout_vld          <= s2_vld;
            sync_out          <= s2_sync;
            last_triangle_out <= s2_lt & s2_vld;
            buf_sel_out       <= s2_bs & s2_vld;
            if (s2_sync || s2_vld) bl_idx <= idx_cur;
            if (s2_vld)
                next_idx <= (idx_cur == LAST_IDX) ? '0 : idx_cur + 1'b1;
            else if (s2_sync)
                next_idx <= '0;
            if (s2_sync)
                sat_flag <= sat_any;
            else if (s2_vld)
                sat_flag <= sat_flag | sat_any;
        end
    end

    assign window_done = dout_vld & (bl_idx == LAST_IDX);

endmodule

// File: tb/tb_xeng_corr_apply.sv
// Directed bench for xeng_corr_apply: scoreboard queue of expected beats compared
// three cycles after each drive, plus reset and mid-stream reset checks.
module tb_xeng_corr_apply;

    localparam int ACC = 32;
    localparam int CW  = 16;
    localparam int OW  = 24;
    localparam int NB  = 10;

    typedef struct {
        logic [8*OW-1:0] d;
        logic [4:0]      f;
        logic [3:0]      idx;
        logic            sat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sync = 1'b0;
    logic            din_vld = 1'b0;
    logic            lt_in = 1'b0;
    logic            bs_in = 1'b0;
    logic [8*ACC-1:0] din = '0;
    logic [8*CW-1:0]  corr = '0;
    logic [8*OW-1:0]  dout;
    logic            dout_vld, sync_out, lt_out, bs_out, window_done, sat_flag;
    logic [3:0]      bl_idx;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t q[$];
    longint raw_l [8];
    longint cor_l [8];

    logic [8*OW-1:0] m_d;
    int              m_next, m_bl;
    bit              m_sat;

    always #5 clk = ~clk;

    xeng_corr_apply #(
        .BITWIDTH(4), .N_ANTS(4), .ACC_WIDTH(ACC), .CORR_WIDTH(CW),
        .OUT_WIDTH(OW), .RE_CONST(64)
    ) dut (
        .clk(clk), .rst(rst), .sync(sync), .din_vld(din_vld), .din(din), .corr(corr),
        .last_triangle_in(lt_in), .buf_sel_in(bs_in), .dout(dout), .dout_vld(dout_vld),
        .sync_out(sync_out), .last_triangle_out(lt_out), .buf_sel_out(bs_out),
        .bl_idx(bl_idx), .window_done(window_done), .sat_flag(sat_flag)
    );

    task automatic chk(input string tag, input logic [8*OW-1:0] obs, input logic [8*OW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"}, dout, '0);
        chk({tag, "_flags"}, {dout_vld, sync_out, lt_out, bs_out, window_done}, '0);
        chk({tag, "_bl_idx"}, bl_idx, '0);
        chk({tag, "_sat"}, sat_flag, '0);
    endtask

    task automatic model_reset();
        q.delete();
        m_d = '0; m_next = 0; m_bl = 0; m_sat = 1'b0;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 8; i++) begin
            raw_l[i] = longint'($urandom_range(0, 2000000)) - 1000000;
            cor_l[i] = longint'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    task automatic beat(input bit v, input bit s, input bit lt, input bit bs);
        exp_t   e;
        exp_t   o;
        bit     anyc;
        int     idx;
        longint val;
        logic [63:0] vb;
        for (int i = 0; i < 8; i++) begin
            vb = raw_l[i];
            din[(7-i)*ACC +: ACC] = vb[ACC-1:0];
            vb = cor_l[i];
            corr[(7-i)*CW +: CW] = vb[CW-1:0];
        end
        din_vld = v; sync = s; lt_in = lt; bs_in = bs;

        anyc = 1'b0;
        e.d = m_d;
        if (v) begin
            for (int i = 0; i < 8; i++) begin
                val = raw_l[i] - cor_l[i] * 8 + ((i < 4) ? 64 : 0);
                if (val > 8388607) begin
                    val = 8388607; anyc = 1'b1;
                end else if (val < -8388608) begin
                    val = -8388608; anyc = 1'b1;
                end
                vb = val;
                e.d[(7-i)*OW +: OW] = vb[OW-1:0];
            end
        end
        m_d = e.d;
        idx = s ? 0 : m_next;
        if (s || v) m_bl = idx;
        if (v) m_next = (idx == NB - 1) ? 0 : idx + 1;
        else if (s) m_next = 0;
        if (s) m_sat = anyc;
        else if (v) m_sat = m_sat | anyc;
        e.f   = {v, s, lt & v, bs & v, v && (m_bl == NB - 1)};
        e.idx = m_bl[3:0];
        e.sat = m_sat;
        q.push_back(e);

        @(posedge clk);
        #1;
        if (q.size() == 3) begin
            o = q.pop_front();
            chk("dout", dout, o.d);
            chk("flags", {dout_vld, sync_out, lt_out, bs_out, window_done}, o.f);
            chk("bl_idx", bl_idx, o.idx);
            chk("sat_flag", sat_flag, o.sat);
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 8; i++) begin raw_l[i] = 0; cor_l[i] = 0; end
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // idle beats after reset: outputs stay at reset values
        for (int i = 0; i < 3; i++) beat(0, 0, 0, 0);

        // window 1: nominal real and imag lanes on the sync beat
        set_rand();
        raw_l[0] = 1000; cor_l[0] = 5;
        raw_l[5] = -200; cor_l[5] = -3;
        beat(1, 1, 0, 0);
        for (int i = 1; i < NB; i++) begin
            set_rand();
            beat(1, 0, i == NB - 1, i[0]);
        end
        // five more into the next window, one positive saturation
        for (int i = 0; i < 5; i++) begin
            set_rand();
            if (i == 2) begin raw_l[3] = 64'sd1 << 30; cor_l[3] = 0; end
            beat(1, 0, 0, 1);
        end
        // gaps with toggling flags; sat_flag remains sticky
        for (int i = 0; i < 20; i++) begin
            set_rand();
            beat($urandom_range(0, 1) == 1, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        // sync with no saturation clears sat_flag
        set_rand();
        beat(1, 1, 0, 0);
        // boundary values around the clamp points
        set_rand();
        raw_l[0] = 8388543; cor_l[0] = 0;
        raw_l[4] = 8388607; cor_l[4] = 0;
        raw_l[6] = -8388608; cor_l[6] = 0;
        beat(1, 0, 0, 0);
        set_rand();
        raw_l[1] = 8388544; cor_l[1] = 0;
        beat(1, 0, 0, 0);
        set_rand();
        raw_l[5] = -64'sd2147483648; cor_l[5] = 32767;
        raw_l[2] = 2147483647; cor_l[2] = -32768;
        beat(1, 0, 0, 0);
        // sync on a beat that saturates keeps sat_flag set
        set_rand();
        raw_l[7] = -64'sd2147483648; cor_l[7] = 0;
        beat(1, 1, 0, 0);
        // sync without data, then back-to-back syncs
        set_rand();
        beat(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin set_rand(); beat(1, 0, 0, 0); end
        set_rand(); beat(1, 1, 0, 1);
        set_rand(); beat(1, 1, 1, 0);
        // run to index 9, then sync where the counter would wrap
        for (int i = 0; i < NB - 1; i++) begin set_rand(); beat(1, 0, 0, 0); end
        set_rand(); beat(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin set_rand(); beat(1, 0, 0, 0); end

        // mid-stream reset, asserted between clock edges
        #1;
        rst = 1'b1;
        din_vld = 1'b0; sync = 1'b0;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        #3;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin raw_l[i] = 0; cor_l[i] = 0; end
        for (int i = 0; i < 3; i++) beat(0, 0, 0, 0);
        set_rand();
        raw_l[0] = 1000; cor_l[0] = 5;
        beat(1, 1, 0, 0);
        for (int i = 1; i < 12; i++) begin set_rand(); beat(1, 0, 0, 0); end
        for (int i = 0; i < 3; i++) beat(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
